// File: rtl/bw_io_ic_filter_sync.sv
// Multi-channel pad receive filter: per-channel synchroniser, glitch filter,
// bypass, pad-supply gating and registered edge pulses.

module bw_io_ic_filter_sync_lane #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             vddo,
    input  logic             bypass,
    input  logic [CNT_W-1:0] filt_len,
    input  logic             pad,
    output logic             lvl,
    output logic             rise,
    output logic             fall,
    output logic             edge_nxt
);
    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic                   s, lvl_nxt, rise_nxt, fall_nxt, clr;

    assign s   = sync[SYNC_STAGES-1];
    assign clr = reset | ~vddo;

    // cnt only increments while below filt_len, so it can never wrap.
    always_comb begin
        lvl_nxt = lvl;
        cnt_nxt = cnt;
        if (bypass) begin
            lvl_nxt = s;
            cnt_nxt = '0;
        end else if (s == lvl) begin
            cnt_nxt = '0;
        end else if (cnt >= filt_len) begin
            lvl_nxt = s;
            cnt_nxt = '0;
        end else begin
            cnt_nxt = cnt + 1'b1;
        end
        rise_nxt = lvl_nxt & ~lvl;
        fall_nxt = ~lvl_nxt & lvl;
    end

    assign edge_nxt = rise_nxt | fall_nxt;

    always_ff @(posedge clk) begin
        if (clr) begin
            sync <= '0;
            cnt  <= '0;
            lvl  <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pad};
            cnt  <= cnt_nxt;
            lvl  <= lvl_nxt;
            rise <= rise_nxt;
            fall <= fall_nxt;
        end
    end
endmodule

module bw_io_ic_filter_sync #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             vddo,
    input  logic             bypass,
    input  logic [CNT_W-1:0] filt_len,
    input  logic [WIDTH-1:0] topad,
    output logic [WIDTH-1:0] torcvr,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             chg_any
);
    logic [WIDTH-1:0] edge_nxt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        bw_io_ic_filter_sync_lane #(
            .SYNC_STAGES(SYNC_STAGES),
            .CNT_W      (CNT_W)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .vddo    (vddo),
            .bypass  (bypass),
            .filt_len(filt_len),
            .pad     (topad[i]),
            .lvl     (torcvr[i]),
            .rise    (rise[i]),
            .fall    (fall[i]),
            .edge_nxt(edge_nxt[i])
        );
    end

    // Registered from the lanes' next-state so it lines up with rise/fall.
    always_ff @(posedge clk) begin
        if (reset || !vddo) chg_any <= 1'b0;
        else                chg_any <= |edge_nxt;
    end
endmodule

// File: tb/tb_bw_io_ic_filter_sync.sv
// Directed bench for bw_io_ic_filter_sync with hand-computed expectations.

module tb_bw_io_ic_filter_sync;
    logic       clk = 1'b0;
    logic       reset, vddo, bypass;
    logic [3:0] filt_len;
    logic [7:0] topad, torcvr, rise, fall;
    logic       chg_any;
    int         total = 0;
    int         bad = 0;
    logic [7:0] fall_seen, rise_seen;

    bw_io_ic_filter_sync dut (
        .clk(clk), .reset(reset), .vddo(vddo), .bypass(bypass),
        .filt_len(filt_len), .topad(topad), .torcvr(torcvr),
        .rise(rise), .fall(fall), .chg_any(chg_any)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; vddo = 1'b1; bypass = 1'b0; filt_len = 4'd3; topad = 8'hFF;
        step(3);
        // 1: reset state, then acquire all-ones at E0+2+3
        chk("t1_rst_rcvr", torcvr, 8'h00);
        chk("t1_rst_rise", rise, 8'h00);
        chk("t1_rst_fall", fall, 8'h00);
        chk("t1_rst_chg", chg_any, 1'b0);
        reset = 1'b0;
        step(5);
        chk("t1_pre_rcvr", torcvr, 8'h00);
        step(1);
        chk("t1_acq_rcvr", torcvr, 8'hFF);
        chk("t1_acq_rise", rise, 8'hFF);
        chk("t1_acq_chg", chg_any, 1'b1);
        step(1);
        chk("t1_rise_clr", rise, 8'h00);
        chk("t1_chg_clr", chg_any, 1'b0);

        // 2: 3-cycle glitch rejected, 4-cycle glitch accepted
        topad = 8'hFE;
        fall_seen = 8'h00;
        step(3);
        topad = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            fall_seen |= fall;
            step(1);
        end
        chk("t2_short_fall", fall_seen, 8'h00);
        chk("t2_short_rcvr", torcvr, 8'hFF);
        topad = 8'hFE;
        step(4);
        topad = 8'hFF;
        step(1);
        chk("t2_long_hold", torcvr, 8'hFF);
        step(1);
        chk("t2_long_rcvr", torcvr, 8'hFE);
        chk("t2_long_fall", fall, 8'h01);
        chk("t2_long_rise", rise, 8'h00);
        chk("t2_long_chg", chg_any, 1'b1);
        step(1);
        chk("t2_fall_clr", fall, 8'h00);
        step(3);
        chk("t2_back_rcvr", torcvr, 8'hFF);
        chk("t2_back_rise", rise, 8'h01);
        step(1);

        // 3: bypass ignores filt_len, 2-edge lag
        bypass = 1'b1; filt_len = 4'd15;
        for (int k = 0; k < 4; k++) begin
            logic [7:0] prev, nxt;
            prev = torcvr;
            nxt = prev ^ 8'h04;
            topad = nxt;
            step(2);
            chk("t3_lag", torcvr, prev);
            step(1);
            chk("t3_rcvr", torcvr, nxt);
            chk("t3_rise", rise, nxt[2] ? 8'h04 : 8'h00);
            chk("t3_fall", fall, nxt[2] ? 8'h00 : 8'h04);
            step(1);
            chk("t3_pulse_clr", rise | fall, 8'h00);
        end

        // 4: lowering filt_len mid-count accepts at next edge
        bypass = 1'b0; filt_len = 4'd15;
        topad = 8'hF7;
        step(12);
        chk("t4_hold", torcvr, 8'hFF);
        filt_len = 4'd5;
        step(1);
        chk("t4_rcvr", torcvr, 8'hF7);
        chk("t4_fall", fall, 8'h08);
        filt_len = 4'd0;
        topad = 8'hFF;
        step(3);
        chk("t4_back", torcvr, 8'hFF);
        step(1);

        // 5: supply drop clears without pulses, then reacquire
        topad = 8'hA5;
        step(3);
        chk("t5_rcvr", torcvr, 8'hA5);
        chk("t5_fall", fall, 8'h5A);
        step(1);
        vddo = 1'b0;
        step(1);
        chk("t5_off_rcvr", torcvr, 8'h00);
        chk("t5_off_fall", fall, 8'h00);
        chk("t5_off_chg", chg_any, 1'b0);
        step(2);
        filt_len = 4'd2;
        vddo = 1'b1;
        step(4);
        chk("t5_reacq_pre", torcvr, 8'h00);
        step(1);
        chk("t5_reacq", torcvr, 8'hA5);
        chk("t5_reacq_rise", rise, 8'hA5);
        step(1);

        // 6: all channels at once, then mid-count reset
        filt_len = 4'd0;
        topad = 8'h5A;
        step(2);
        chk("t6_pre", torcvr, 8'hA5);
        step(1);
        chk("t6_rcvr", torcvr, 8'h5A);
        chk("t6_rise", rise, 8'h5A);
        chk("t6_fall", fall, 8'hA5);
        chk("t6_chg", chg_any, 1'b1);
        step(1);
        chk("t6_chg_clr", chg_any, 1'b0);
        filt_len = 4'd7;
        topad = 8'hA5;
        step(4);
        chk("t6_mid", torcvr, 8'h5A);
        reset = 1'b1;
        step(1);
        chk("t6_rst_rcvr", torcvr, 8'h00);
        chk("t6_rst_pulse", rise | fall, 8'h00);
        chk("t6_rst_chg", chg_any, 1'b0);
        reset = 1'b0;
        rise_seen = 8'h00;
        for (int k = 0; k < 3; k++) begin
            step(1);
            rise_seen |= rise;
        end
        chk("t6_post_rst", torcvr | rise_seen, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
